// File: rtl/ad98xx_cfg_pkg.sv
// Shared types and elaboration-time helpers for the AD98xx serial register
// port master.
//   state_t    : controller state encoding
//   frame_w    : total serial frame width {rw, addr, dc, data}
//   dev_w      : width of the device index (at least one bit)
//   cnt_w      : width of the half-period counter for a given divider
//   off_*      : bit position of the least significant bit of each frame field
package ad98xx_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_HOLD  = 3'd2,
        ST_GAP   = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    function automatic int frame_w(input int addr_w, input int dc_w, input int data_w);
        return 1 + addr_w + dc_w + data_w;
    endfunction

    function automatic int dev_w(input int num_dev);
        return (num_dev > 1) ? $clog2(num_dev) : 1;
    endfunction

    function automatic int cnt_w(input int clk_div);
        return (clk_div > 1) ? $clog2(clk_div) : 1;
    endfunction

    function automatic int off_rw(input int addr_w, input int dc_w, input int data_w);
        return addr_w + dc_w + data_w;
    endfunction

    function automatic int off_addr(input int dc_w, input int data_w);
        return dc_w + data_w;
    endfunction

    function automatic int off_dc(input int data_w);
        return data_w;
    endfunction

    function automatic int off_data();
        return 0;
    endfunction

endpackage

// File: rtl/ad98xx_serial_cfg_if.sv
// Command/response handshake bundle between a host and the AD98xx serial
// register port master.
//   cmd_valid/cmd_ready : command handshake, cmd_word = {rw, addr, dc, data}
//   cmd_dev             : target device index
//   rsp_valid/rsp_ready : response handshake
//   rsp_word            : header echo plus written or read-back data
//   rsp_err             : device index was out of range, no frame issued
// Modports: master = host side, slave = serial port master side.
interface ad98xx_serial_cfg_if #(
    parameter int FRAME_W = 16,
    parameter int DEV_W   = 1
) ();

    logic               cmd_valid;
    logic               cmd_ready;
    logic [FRAME_W-1:0] cmd_word;
    logic [DEV_W-1:0]   cmd_dev;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [FRAME_W-1:0] rsp_word;
    logic               rsp_err;

    modport master (
        output cmd_valid, cmd_word, cmd_dev, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_word, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_word, cmd_dev, rsp_ready,
        output cmd_ready, rsp_valid, rsp_word, rsp_err
    );

endinterface

// File: rtl/ad98xx_sclk_gen.sv
// Serial clock generator: divides clk into SCLK half-periods of CLK_DIV cycles.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   enable      : counter runs while high, held at zero otherwise
//   toggle_en   : level toggles on half ticks while high, forced low otherwise
//   half_tick   : last clk cycle of the current half-period
//   sclk_level  : registered SCLK level, starts each enabled period low
module ad98xx_sclk_gen
    import ad98xx_cfg_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic toggle_en,
    output logic half_tick,
    output logic sclk_level
);

    localparam int CNT_W = cnt_w(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign half_tick = enable && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            sclk_level <= 1'b0;
        end else begin
            if (!enable || half_tick) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (!toggle_en) begin
                sclk_level <= 1'b0;
            end else if (half_tick) begin
                sclk_level <= ~sclk_level;
            end
        end
    end

endmodule

// File: rtl/ad98xx_serial_cfg.sv
// Master for the 3-wire SCLK/SLOAD/SDATA register port of AD98xx CCD front
// ends. One command at a time is shifted out MSB first on a divided SCLK; the
// response carries the header echo plus written data or sampled readback.
//   clk, rst_n          : system clock, asynchronous active-low reset
//   host                : command/response handshake (slave modport)
//   sclk                : registered serial clock, idles low
//   sload_n[NUM_DEV]    : per-device load strobe, active low
//   sdata_o/oe, sdata_i : SDATA tristate split, pad buffer lives above
//   busy                : controller is not idle
module ad98xx_serial_cfg
    import ad98xx_cfg_pkg::*;
#(
    parameter int ADDR_W  = 3,
    parameter int DC_W    = 3,
    parameter int DATA_W  = 9,
    parameter int NUM_DEV = 1,
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    ad98xx_serial_cfg_if.slave host,
    output logic               sclk,
    output logic [NUM_DEV-1:0] sload_n,
    output logic               sdata_o,
    output logic               sdata_oe,
    input  logic               sdata_i,
    output logic               busy
);

    localparam int FRAME_W = frame_w(ADDR_W, DC_W, DATA_W);
    localparam int DEV_W   = dev_w(NUM_DEV);
    localparam int IDX_W   = $clog2(FRAME_W);

    localparam logic [IDX_W-1:0] IDX_TOP     = IDX_W'(FRAME_W - 1);
    localparam logic [IDX_W-1:0] IDX_RW      = IDX_W'(off_rw(ADDR_W, DC_W, DATA_W));
    localparam logic [IDX_W-1:0] IDX_ADDR_LO = IDX_W'(off_addr(DC_W, DATA_W));
    localparam logic [IDX_W-1:0] IDX_DC_LO   = IDX_W'(off_dc(DATA_W));

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] word_q, word_d;
    logic [DEV_W-1:0]   dev_q, dev_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  rd_q, rd_d;
    logic               err_q, err_d;

    logic [NUM_DEV-1:0] sload_n_q, sload_n_d;
    logic               sdata_o_q, sdata_o_d;
    logic               sdata_oe_q, sdata_oe_d;
    logic [FRAME_W-1:0] rsp_word_q, rsp_word_d;
    logic               cmd_ready_q, rsp_valid_q, busy_q;

    logic half_tick;
    logic sclk_level;
    logic gen_enable;
    logic gen_toggle;
    logic dev_ok;

    assign gen_enable = (state_q == ST_SHIFT) || (state_q == ST_HOLD) || (state_q == ST_GAP);
    assign gen_toggle = (state_q == ST_SHIFT);
    assign dev_ok     = (32'(host.cmd_dev) < 32'(NUM_DEV));

    ad98xx_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (gen_enable),
        .toggle_en  (gen_toggle),
        .half_tick  (half_tick),
        .sclk_level (sclk_level)
    );

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        dev_d   = dev_q;
        idx_d   = idx_q;
        rd_d    = rd_q;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (host.cmd_valid) begin
                    word_d = host.cmd_word;
                    dev_d  = host.cmd_dev;
                    idx_d  = IDX_TOP;
                    rd_d   = '0;
                    err_d  = !dev_ok;
                    state_d = dev_ok ? ST_SHIFT : ST_RESP;
                end
            end
            ST_SHIFT: begin
                // A tick while SCLK is high closes the current bit.
                if (half_tick && sclk_level) begin
                    if (word_q[IDX_RW] && (idx_q < IDX_DC_LO)) begin
                        rd_d = DATA_W'({rd_q, sdata_i});
                    end
                    if (idx_q == '0) begin
                        state_d = ST_HOLD;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (half_tick) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (half_tick) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (host.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pin outputs are registered from the next state so they line up
        // with the state they belong to.
        sload_n_d  = '1;
        sdata_o_d  = 1'b0;
        sdata_oe_d = 1'b0;
        if ((state_d == ST_SHIFT) || (state_d == ST_HOLD)) begin
            sload_n_d = ~(NUM_DEV'(1) << dev_d);
        end
        if (state_d == ST_SHIFT) begin
            sdata_oe_d = (idx_d >= IDX_ADDR_LO) || ((idx_d < IDX_DC_LO) && !word_d[IDX_RW]);
            sdata_o_d  = sdata_oe_d && word_d[idx_d];
        end

        rsp_word_d = rsp_word_q;
        if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
            rsp_word_d = {word_d[FRAME_W-1:DATA_W],
                          word_d[IDX_RW] ? rd_d : word_d[DATA_W-1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            dev_q       <= '0;
            idx_q       <= '0;
            rd_q        <= '0;
            err_q       <= 1'b0;
            sload_n_q   <= '1;
            sdata_o_q   <= 1'b0;
            sdata_oe_q  <= 1'b0;
            rsp_word_q  <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            dev_q       <= dev_d;
            idx_q       <= idx_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
            sload_n_q   <= sload_n_d;
            sdata_o_q   <= sdata_o_d;
            sdata_oe_q  <= sdata_oe_d;
            rsp_word_q  <= rsp_word_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_RESP);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign sclk           = sclk_level;
    assign sload_n        = sload_n_q;
    assign sdata_o        = sdata_o_q;
    assign sdata_oe       = sdata_oe_q;
    assign busy           = busy_q;
    assign host.cmd_ready = cmd_ready_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_word  = rsp_word_q;
    assign host.rsp_err   = err_q;

endmodule

// File: tb/tb_ad98xx_serial_cfg.sv
// Directed bench for ad98xx_serial_cfg: dut_a at defaults (1 device, CLK_DIV 4),
// dut_b with 3 devices and CLK_DIV 1.
module tb_ad98xx_serial_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks;
    int   failures;

    ad98xx_serial_cfg_if #(.FRAME_W(16), .DEV_W(1)) ia ();
    ad98xx_serial_cfg_if #(.FRAME_W(16), .DEV_W(2)) ib ();

    logic       sclk_a, sdo_a, soe_a, sdi_a, busy_a;
    logic [0:0] sload_a;
    logic       sclk_b, sdo_b, soe_b, sdi_b, busy_b;
    logic [2:0] sload_b;

    ad98xx_serial_cfg dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .host     (ia.slave),
        .sclk     (sclk_a),
        .sload_n  (sload_a),
        .sdata_o  (sdo_a),
        .sdata_oe (soe_a),
        .sdata_i  (sdi_a),
        .busy     (busy_a)
    );

    ad98xx_serial_cfg #(
        .NUM_DEV (3),
        .CLK_DIV (1)
    ) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .host     (ib.slave),
        .sclk     (sclk_b),
        .sload_n  (sload_b),
        .sdata_o  (sdo_b),
        .sdata_oe (soe_b),
        .sdata_i  (sdi_b),
        .busy     (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one frame to dut_a (device 0) and follows it until rsp_valid.
    // Returns with the response on the outputs; lat counts from the accept edge.
    task automatic frame_a(input logic [15:0] w, input logic [8:0] rdv,
                           output int lat, output logic [15:0] sd, output logic [15:0] oe,
                           output int rises, output int sload_bad);
        logic prev;
        int   idx;
        ia.cmd_word  = w;
        ia.cmd_dev   = 1'b0;
        ia.cmd_valid = 1'b1;
        step();
        ia.cmd_valid = 1'b0;
        lat = 1; rises = 0; sload_bad = 0; sd = '0; oe = '0; prev = 1'b0;
        while (!ia.rsp_valid && lat < 1000) begin
            if (sclk_a && !prev) begin
                rises++;
                idx = 16 - rises;
                if (idx >= 0) begin
                    sd[idx] = sdo_a;
                    oe[idx] = soe_a;
                    if (w[15] && idx < 9) sdi_a = rdv[idx];
                end
            end
            if (sload_a !== ((lat <= 132) ? 1'b0 : 1'b1)) sload_bad++;
            prev = sclk_a;
            step();
            lat++;
        end
        sdi_a = 1'b0;
    endtask

    int          lat, rises, sload_bad, n, bad;
    logic [15:0] sd, oe;
    logic [2:0]  seen;
    logic        prev;

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        ia.cmd_valid = 1'b0; ia.cmd_word = '0; ia.cmd_dev = '0; ia.rsp_ready = 1'b1;
        ib.cmd_valid = 1'b0; ib.cmd_word = '0; ib.cmd_dev = '0; ib.rsp_ready = 1'b1;
        sdi_a = 1'b0; sdi_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_a_pins", 32'({sclk_a, sload_a, sdo_a, soe_a, ia.cmd_ready, ia.rsp_valid, ia.rsp_err, busy_a}),
              32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
        check("reset_a_rsp_word", 32'(ia.rsp_word), 32'h0);
        check("reset_b_pins", 32'({sclk_b, sload_b, sdo_b, soe_b, ib.cmd_ready, ib.rsp_valid, ib.rsp_err, busy_b}),
              32'({1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
        rst_n = 1'b1;
        step();

        // Write 0x10A5 at defaults.
        frame_a(16'h10A5, 9'h0, lat, sd, oe, rises, sload_bad);
        check("wr_latency", 32'(lat), 32'd137);
        check("wr_sclk_rises", 32'(rises), 32'd16);
        check("wr_sdata", 32'(sd), 32'h10A5);
        check("wr_oe_mask", 32'(oe), 32'hF1FF);
        check("wr_sload_window", 32'(sload_bad), 32'd0);
        check("wr_rsp_word", 32'(ia.rsp_word), 32'h10A5);
        check("wr_rsp_err", 32'(ia.rsp_err), 32'd0);
        step();
        check("wr_rsp_done", 32'({ia.rsp_valid, ia.cmd_ready, busy_a}), 32'b010);

        // Read 0x9000, device returns 0x1C3.
        frame_a(16'h9000, 9'h1C3, lat, sd, oe, rises, sload_bad);
        check("rd_latency", 32'(lat), 32'd137);
        check("rd_sdata", 32'(sd), 32'h9000);
        check("rd_oe_mask", 32'(oe), 32'hF000);
        check("rd_sload_window", 32'(sload_bad), 32'd0);
        check("rd_rsp_word", 32'(ia.rsp_word), 32'h91C3);
        check("rd_rsp_err", 32'(ia.rsp_err), 32'd0);
        step();

        // Backpressure with a second command pending.
        ia.rsp_ready = 1'b0;
        ia.cmd_word = 16'h10A5; ia.cmd_dev = 1'b0; ia.cmd_valid = 1'b1;
        step();
        ia.cmd_word = 16'h2155;
        n = 0;
        while (!ia.rsp_valid && n < 1000) begin step(); n++; end
        check("bp_first_rsp", 32'(ia.rsp_word), 32'h10A5);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (ia.cmd_ready !== 1'b0 || sclk_a !== 1'b0 || sload_a !== 1'b1 ||
                ia.rsp_valid !== 1'b1 || ia.rsp_word !== 16'h10A5) bad++;
            step();
        end
        check("bp_stall_quiet", 32'(bad), 32'd0);
        ia.rsp_ready = 1'b1;
        step();
        check("bp_handshake", 32'({ia.rsp_valid, ia.cmd_ready, sload_a}), 32'b011);
        step();
        check("bp_second_start", 32'({sload_a, busy_a, ia.cmd_ready}), 32'b010);
        ia.cmd_valid = 1'b0;
        n = 0;
        while (!ia.rsp_valid && n < 1000) begin step(); n++; end
        check("bp_second_rsp", 32'(ia.rsp_word), 32'h2155);
        step();

        // Reset during bit 7.
        ia.cmd_word = 16'h10A5; ia.cmd_valid = 1'b1;
        step();
        ia.cmd_valid = 1'b0;
        rises = 0; n = 0; prev = 1'b0;
        while (rises < 9 && n < 500) begin
            if (sclk_a && !prev) rises++;
            prev = sclk_a;
            if (rises < 9) begin step(); n++; end
        end
        check("mid_reached_bit7", 32'({busy_a, sload_a, sclk_a}), 32'b101);
        rst_n = 1'b0;
        #1;
        check("mid_async_reset", 32'({sclk_a, sload_a, soe_a, sdo_a, busy_a, ia.cmd_ready, ia.rsp_valid}),
              32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
        step(); step();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (ia.rsp_valid !== 1'b0 || sload_a !== 1'b1) bad++;
            step();
        end
        check("mid_no_response", 32'(bad), 32'd0);
        frame_a(16'h10A5, 9'h0, lat, sd, oe, rises, sload_bad);
        check("post_reset_latency", 32'(lat), 32'd137);
        check("post_reset_rsp", 32'(ia.rsp_word), 32'h10A5);
        step();

        // dut_b: invalid device index.
        ib.cmd_word = 16'h10A5; ib.cmd_dev = 2'd3; ib.cmd_valid = 1'b1;
        step();
        ib.cmd_valid = 1'b0;
        check("inv_rsp_cycle1", 32'({ib.rsp_valid, ib.rsp_err}), 32'b11);
        check("inv_lines_idle", 32'({sload_b, sclk_b, soe_b}), 32'b11100);
        step();
        check("inv_done", 32'({ib.rsp_valid, ib.cmd_ready, sload_b, sclk_b}), 32'b011110);

        // dut_b: device 2 write with CLK_DIV 1.
        ib.cmd_word = 16'h10A5; ib.cmd_dev = 2'd2; ib.cmd_valid = 1'b1;
        step();
        ib.cmd_valid = 1'b0;
        lat = 1; seen = '0; rises = 0; prev = 1'b0;
        while (!ib.rsp_valid && lat < 500) begin
            seen = seen | ~sload_b;
            if (sclk_b && !prev) rises++;
            prev = sclk_b;
            step();
            lat++;
        end
        check("dev2_latency", 32'(lat), 32'd35);
        check("dev2_sload_sel", 32'(seen), 32'b100);
        check("dev2_sclk_rises", 32'(rises), 32'd16);
        check("dev2_rsp", 32'({ib.rsp_err, ib.rsp_word}), 32'({1'b0, 16'h10A5}));
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
